// File: rtl/fetch_stage_if.sv
// Interface between the fetch stage and its surroundings.
// Carries the ID redirect inputs, the instruction-memory link and the IF/ID register outputs.
interface fetch_stage_if #(
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned WORD_LEN    = 32
) ();
  logic                   stall;
  logic                   branch_taken;
  logic [15:0]            branch_offset;
  logic                   jump;
  logic [25:0]            jump_target;
  logic [WORD_LEN-1:0]    inst_in;
  logic [ADDRESS_LEN-1:0] pc_out;
  logic [WORD_LEN-1:0]    if_id_inst;
  logic [ADDRESS_LEN-1:0] if_id_pc_plus1;
  logic                   if_id_valid;
  logic [31:0]            fetch_count;
  logic                   fetch_fault;

  // The fetch stage owns the PC and the IF/ID register.
  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, inst_in,
    output pc_out, if_id_inst, if_id_pc_plus1, if_id_valid, fetch_count, fetch_fault
  );

  // Hazard unit, ID stage and instruction memory.
  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, inst_in,
    input  pc_out, if_id_inst, if_id_pc_plus1, if_id_valid, fetch_count, fetch_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: program counter, IF/ID register and redirect handling.
// Redirects from ID insert one bubble; out-of-range targets restart at RESET_PC and latch a fault.
module fetch_stage #(
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned WORD_LEN    = 32,
  parameter int unsigned MEMORY_SIZE = 256,
  parameter int unsigned RESET_PC    = 0
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);

  localparam int unsigned OFFSET_LEN = 16;
  localparam int unsigned COUNT_LEN  = 32;
  localparam logic [ADDRESS_LEN-1:0] PC_INIT   = ADDRESS_LEN'(RESET_PC);
  localparam logic [ADDRESS_LEN-1:0] LAST_PC   = ADDRESS_LEN'(MEMORY_SIZE - 1);
  localparam logic [ADDRESS_LEN-1:0] MEM_LIMIT = ADDRESS_LEN'(MEMORY_SIZE);

  typedef enum logic {BOOT, RUN} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESS_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0]    inst_q, inst_d;
  logic [ADDRESS_LEN-1:0] pc_plus1_q, pc_plus1_d;
  logic                   valid_q, valid_d;
  logic [COUNT_LEN-1:0]   count_q, count_d;
  logic                   fault_q, fault_d;

  logic [ADDRESS_LEN-1:0] seq_pc;
  logic [ADDRESS_LEN-1:0] br_pc;
  logic [ADDRESS_LEN-1:0] jmp_pc;
  logic [ADDRESS_LEN-1:0] redirect_pc;

  // Candidate next PCs, all from registered state plus the ID-stage fields.
  assign seq_pc = (pc_q == LAST_PC) ? '0 : pc_q + ADDRESS_LEN'(1);
  assign br_pc  = pc_plus1_q +
                  {{(ADDRESS_LEN-OFFSET_LEN){bus.branch_offset[OFFSET_LEN-1]}}, bus.branch_offset};
  assign jmp_pc = ADDRESS_LEN'(bus.jump_target);
  assign redirect_pc = bus.jump ? jmp_pc : br_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= PC_INIT;
      inst_q     <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    count_d    = count_q;
    fault_d    = fault_q;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.jump || bus.branch_taken) begin
          // Redirect beats stall; the wrong-path word is dropped for a bubble.
          inst_d     = '0;
          pc_plus1_d = '0;
          valid_d    = 1'b0;
          if (redirect_pc >= MEM_LIMIT) begin
            pc_d    = PC_INIT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (!bus.stall) begin
          inst_d     = bus.inst_in;
          pc_plus1_d = seq_pc;
          valid_d    = 1'b1;
          pc_d       = seq_pc;
          count_d    = count_q + COUNT_LEN'(1);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.pc_out         = pc_q;
  assign bus.if_id_inst     = inst_q;
  assign bus.if_id_pc_plus1 = pc_plus1_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_count    = count_q;
  assign bus.fetch_fault    = fault_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the word-addressed program counter and drives the address input of the instruction memory.
- Captures the combinational instruction word into the IF/ID pipeline register.
- Applies stall, taken-branch and jump redirects resolved in ID, inserting a bubble on every redirect.

Parameters:
- ADDRESS_LEN, 32, PC / instruction-address width.
- WORD_LEN, 32, instruction word width.
- MEMORY_SIZE, 256, number of instruction-memory words; valid PCs are 0..MEMORY_SIZE-1.
- RESET_PC, 0, PC value after reset and after a fetch fault.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit freeze of PC and IF/ID.
- branch_taken  in  1  ID resolved a taken beq/bne.
- branch_offset  in  16  signed word offset from the ID instruction.
- jump  in  1  ID holds a jmp.
- jump_target  in  26  absolute word address field of the jmp.
- inst_in  in  WORD_LEN  instruction-memory data; combinational on pc_out.
- pc_out  out  ADDRESS_LEN  current PC, wired to instruction-memory adr.
- if_id_inst  out  WORD_LEN  IF/ID instruction (32'b0 = nop bubble).
- if_id_pc_plus1  out  ADDRESS_LEN  IF/ID copy of fetch PC + 1.
- if_id_valid  out  1  IF/ID holds a real fetched instruction.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.
- fetch_fault  out  1  sticky; a redirect targeted an address >= MEMORY_SIZE.

Behaviour:
- Reset: rst is asynchronous and active-high, and takes effect immediately, including mid-operation. While rst is high:
  - pc_out = RESET_PC, if_id_inst = 0, if_id_pc_plus1 = 0, if_id_valid = 0;
  - fetch_count = 0, fetch_fault = 0, state = BOOT.
- FSM states:
  - BOOT: the single edge after rst deasserts. PC stays RESET_PC, IF/ID stays a bubble, all inputs are ignored. Next state is RUN.
  - RUN: normal operation; remains in RUN until rst.
- Targets, all computed from the current register outputs:
  - seq = pc_out + 1; if pc_out == MEMORY_SIZE-1, seq = 0.
  - br = if_id_pc_plus1 + sign_extend(branch_offset), mod 2^ADDRESS_LEN.
  - jt = zero_extend(jump_target).
- RUN priority per edge, highest first:
  1. jump: next PC = jt.
  2. branch_taken: next PC = br.
  3. stall: hold the PC.
  4. Otherwise: next PC = seq.
- Redirect (jump or branch_taken), evaluated before stall:
  - IF/ID loads a bubble (inst 0, pc_plus1 0, valid 0); the wrong-path inst_in is discarded.
  - A simultaneous stall is ignored.
- Stall without redirect: PC, IF/ID and fetch_count all hold.
- Normal edge:
  - IF/ID loads {inst_in, seq, 1};
  - PC loads seq;
  - fetch_count increments by 1 and wraps at 2^32.
- Out-of-range target: if the selected jt or br is >= MEMORY_SIZE:
  - PC loads RESET_PC instead;
  - fetch_fault sets and stays 1 until rst;
  - IF/ID loads a bubble, as for any redirect.
- Latency: the instruction at pc_out appears in IF/ID one edge later. A redirect costs exactly one bubble.
- pc_out is a registered output and is never combinationally derived from the inputs.

Test Plan:
1. Reset: run to pc_out = 7, then assert rst between edges → all outputs reset immediately. Release → first edge keeps pc_out = 0 with if_id_valid = 0 (BOOT); next edges give pc_out 1, 2 with if_id_valid = 1 and fetch_count 1, 2.
2. Jump: if_id_pc_plus1 = 1, jump = 1, jump_target = 100 → next edge pc_out = 100, if_id_valid = 0, fetch_count unchanged. Following edge: if_id_inst = memory[100], if_id_pc_plus1 = 101.
3. Branch: if_id_pc_plus1 = 109, offset 16'h0002, branch_taken = 1 → pc_out = 111 plus one bubble. Then if_id_pc_plus1 = 112, offset 16'hFFFC → pc_out = 108.
4. Stall: at pc_out = 105, hold stall high for 3 edges → pc_out, IF/ID and fetch_count unchanged. Drop stall → pc_out = 106 and IF/ID = {memory[105], 106, 1}.
5. Priority: stall = 1 with branch_taken = 1 → branch taken, bubble inserted. jump = 1 (target 10) with branch_taken = 1 (br = 50) → pc_out = 10.
6. Wrap and fault (MEMORY_SIZE = 256):
   - pc_out = 255 → next edge pc_out = 0.
   - jump_target = 300 → pc_out = 0, fetch_fault = 1; fault persists through 20 further edges and clears only on rst.
